// File: rtl/large_int_float_pkg.sv
// Shared constants and state encoding for the wide-integer to float converter.
package large_int_float_pkg;

    localparam int IN_W        = 279;
    localparam int EXP_W       = 8;
    localparam int FRAC_W      = 23;
    localparam int SCALE_SHIFT = 150;

    localparam logic [EXP_W-1:0] EXP_INF       = 8'hFF;
    localparam logic [31:0]      FLOAT_POS_INF = 32'h7F800000;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/chunk_lod.sv
// Leading-one detector over one CHUNK_W-bit slice of the magnitude.
module chunk_lod #(
    parameter int CHUNK_W = 32,
    parameter int IDX_W   = $clog2(CHUNK_W)
) (
    input  logic [CHUNK_W-1:0] chunk,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    // Highest set bit wins because later loop iterations override earlier ones.
    always_comb begin
        found = |chunk;
        index = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            if (chunk[i]) index = IDX_W'(i);
        end
    end

endmodule

// File: rtl/large_integer_to_float.sv
// Multi-cycle converter: 279-bit two's-complement (scale 2^-150) -> IEEE-754 single.
// Optional macro LARGE_INT_TO_FLOAT_RNE_EN selects round-to-nearest-even;
// without it the result is truncated toward zero.
//
// state | meaning
// IDLE  | ready for a new input word
// SCAN  | searching chunk k (top down) for the leading one
// NORM  | normalise, round and register the result
// DONE  | result valid, waiting for the consumer
module large_integer_to_float
    import large_int_float_pkg::*;
#(
    parameter int CHUNK_W = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [IN_W-1:0] in_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     out_o
);

    localparam int NCHUNK = (IN_W + CHUNK_W - 1) / CHUNK_W;
    localparam int PAD_W  = NCHUNK * CHUNK_W;
    localparam int IDX_W  = $clog2(CHUNK_W);
    // Bit position p always fits 9 bits; chunk index takes what the in-chunk index leaves.
    localparam int P_W    = 9;
    localparam int K_W    = P_W - IDX_W;
    localparam int MAN_W  = EXP_W + FRAC_W;

    localparam logic [K_W-1:0] K_TOP   = K_W'(NCHUNK - 1);
    localparam logic [P_W-1:0] P_MSB   = P_W'(IN_W - 1);
    localparam logic [P_W-1:0] P_SAT   = P_W'(FRAC_W);
    localparam logic [P_W-1:0] EXP_OFF = P_W'(SCALE_SHIFT - 127);

    state_t state_q, state_d;

    logic                sign_q;
    logic [IN_W-1:0]     mag_q;
    logic [K_W-1:0]      k_q;
    logic [P_W-1:0]      p_q;
    logic                zero_q;
    logic [31:0]         out_q;

    logic [PAD_W-1:0]    mag_pad;
    logic [CHUNK_W-1:0]  chunk;
    logic                lod_found;
    logic [IDX_W-1:0]    lod_idx;

    logic [P_W-1:0]      shamt;
    logic [P_W-1:0]      exp_raw;
    logic [FRAC_W-1:0]   frac_t;
    logic                round_up;
    logic [MAN_W-1:0]    rounded;
    logic [31:0]         result;

    assign mag_pad = {{(PAD_W - IN_W){1'b0}}, mag_q};
    assign out_o   = out_q;

    // Select the chunk currently under test.
    always_comb begin
        chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (k_q == K_W'(i)) chunk = mag_pad[i*CHUNK_W +: CHUNK_W];
        end
    end

    chunk_lod #(
        .CHUNK_W (CHUNK_W),
        .IDX_W   (IDX_W)
    ) u_lod (
        .chunk (chunk),
        .found (lod_found),
        .index (lod_idx)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) state_d = SCAN;
            end
            SCAN: begin
                if (lod_found || k_q == '0) state_d = NORM;
            end
            NORM: state_d = DONE;
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Normalise so the leading one lands at bit IN_W-1, then pick fraction (and round bits).
    assign shamt   = P_MSB - p_q;
    assign exp_raw = p_q - EXP_OFF;

`ifdef LARGE_INT_TO_FLOAT_RNE_EN
    logic [IN_W-2:0] norm_low;
    logic            guard;
    logic            sticky;

    // Leading one is implicit, so only the bits below it are kept.
    always_comb begin
        norm_low = (IN_W-1)'(mag_q << shamt);
        frac_t   = norm_low[IN_W-2 -: FRAC_W];
        guard    = norm_low[IN_W-2-FRAC_W];
        sticky   = |norm_low[IN_W-3-FRAC_W:0];
        round_up = guard & (sticky | frac_t[0]);
    end
`else
    // Truncation only needs the fraction bits just below the leading one.
    always_comb begin
        frac_t   = FRAC_W'((mag_q << shamt) >> (IN_W - 1 - FRAC_W));
        round_up = 1'b0;
    end
`endif

    assign rounded = {exp_raw[EXP_W-1:0], frac_t} + MAN_W'(round_up);

    // Final result selection; rounding carry can push exp to all-ones, which means infinity.
    always_comb begin
        result = '0;
        if (zero_q) begin
            result = '0;
        end else if (p_q < P_SAT) begin
            result = {sign_q, {EXP_W{1'b0}}, mag_q[FRAC_W-1:0]};
        end else if (p_q == P_SAT) begin
            result = {sign_q, {EXP_W{1'b0}}, {FRAC_W{1'b1}}};
        end else if (exp_raw >= {1'b0, EXP_INF} || rounded[MAN_W-1 -: EXP_W] == EXP_INF) begin
            result = {sign_q, FLOAT_POS_INF[30:0]};
        end else begin
            result = {sign_q, rounded};
        end
    end

    // Datapath registers: capture on accept, walk chunks in SCAN, latch result in NORM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sign_q <= 1'b0;
            mag_q  <= '0;
            k_q    <= '0;
            p_q    <= '0;
            zero_q <= 1'b0;
            out_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        sign_q <= in_i[IN_W-1];
                        mag_q  <= in_i[IN_W-1] ? (~in_i + IN_W'(1)) : in_i;
                        k_q    <= K_TOP;
                        zero_q <= 1'b0;
                    end
                end
                SCAN: begin
                    if (lod_found)      p_q    <= {k_q, lod_idx};
                    else if (k_q == '0) zero_q <= 1'b1;
                    else                k_q    <= k_q - K_W'(1);
                end
                NORM: out_q <= result;
                default: ;
            endcase
        end
    end

endmodule
